// File: rtl/pmu_event_router_pkg.sv
// Shared types and helpers for the PMU event router (mode enum, lane config payload, select width).
package pmu_router_pkg;

    localparam int unsigned LANE_SEL_W   = 16;
    localparam int unsigned LANE_PRESC_W = 4;

    typedef enum logic [1:0] {
        ROUTE_OFF   = 2'b00,
        ROUTE_LEVEL = 2'b01,
        ROUTE_RISE  = 2'b10,
        ROUTE_FALL  = 2'b11
    } route_mode_e;

    typedef struct packed {
        logic [LANE_SEL_W-1:0]   sel;
        route_mode_e             mode;
        logic [LANE_PRESC_W-1:0] presc;
    } lane_cfg_t;

    // Select field width: $clog2 with a floor of one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pmu_event_router_if.sv
// Event/configuration bus between the SoC-side driver (master) and the PMU event router (slave).
interface pmu_event_router_if #(
    parameter int unsigned N_IN    = 32,
    parameter int unsigned N_OUT   = 24,
    parameter int unsigned PRESC_W = 4
);
    localparam int unsigned SEL_W = pmu_router_pkg::sel_width(N_IN);

    logic [N_IN-1:0]          events_i;
    logic [N_OUT*SEL_W-1:0]   cfg_sel_i;
    logic [N_OUT*2-1:0]       cfg_mode_i;
    logic [N_OUT*PRESC_W-1:0] cfg_presc_i;
    logic                     cfg_we_i;
    logic                     commit_i;
    logic [N_OUT-1:0]         events_o;
    logic                     pending_o;

    modport master (
        output events_i, cfg_sel_i, cfg_mode_i, cfg_presc_i, cfg_we_i, commit_i,
        input  events_o, pending_o
    );

    modport slave (
        input  events_i, cfg_sel_i, cfg_mode_i, cfg_presc_i, cfg_we_i, commit_i,
        output events_o, pending_o
    );

endinterface

// File: rtl/pmu_event_router_lane.sv
// One routed lane: select mux, mode qualify, optional prescaler, blanked output flop.
// Prescaler present only when PMU_ROUTER_PRESCALE_EN is defined.
module pmu_router_lane
    import pmu_router_pkg::*;
#(
    parameter int unsigned N_IN    = 32,
    parameter int unsigned PRESC_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic [N_IN-1:0] ev_q_i,
    input  logic [N_IN-1:0] ev_qq_i,
    input  lane_cfg_t       cfg_i,
    output logic            event_o
);

    localparam int unsigned SEL_W = sel_width(N_IN);

    logic [SEL_W-1:0]   idx_c;
    logic               sel_ok_c;
    logic               cur_c;
    logic               prev_c;
    logic               hit_c;
    logic [PRESC_W-1:0] presc_c;
    logic               event_d;
    logic               event_q;

    // Out-of-range selects (non-power-of-two N_IN) behave as an off lane.
    assign idx_c    = SEL_W'(cfg_i.sel);
    assign sel_ok_c = (32'(cfg_i.sel) < N_IN);
    assign cur_c    = sel_ok_c & ev_q_i[idx_c];
    assign prev_c   = sel_ok_c & ev_qq_i[idx_c];
    assign presc_c  = PRESC_W'(cfg_i.presc);

    always_comb begin
        hit_c = 1'b0;
        case (cfg_i.mode)
            ROUTE_LEVEL: hit_c = cur_c;
            ROUTE_RISE:  hit_c = cur_c & ~prev_c;
            ROUTE_FALL:  hit_c = ~cur_c & prev_c;
            default:     hit_c = 1'b0;
        endcase
    end

`ifdef PMU_ROUTER_PRESCALE_EN
    localparam int unsigned CNT_W = (32'd1 << PRESC_W) - 32'd1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] wrap_c;

    assign wrap_c = (CNT_W'(1) << presc_c) - CNT_W'(1);

    // Pulse on every 2^p-th hit; a commit restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        event_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hit_c) begin
            if (cnt_q == wrap_c) begin
                cnt_d   = '0;
                event_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end
`else
    logic unused_presc;
    assign unused_presc = ^presc_c;

    assign event_d = hit_c & ~clear_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_q <= 1'b0;
        end else begin
            event_q <= event_d;
        end
    end
`endif

    assign event_o = event_q;

endmodule

// File: rtl/pmu_event_router.sv
// Registered PMU event crossbar with per-lane modes and double-buffered (shadow/active) configuration.
// Optional per-lane prescaler enabled by defining PMU_ROUTER_PRESCALE_EN.
module pmu_event_router
    import pmu_router_pkg::*;
#(
    parameter int unsigned N_IN    = 32,
    parameter int unsigned N_OUT   = 24,
    parameter int unsigned PRESC_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pmu_event_router_if.slave   rtr_if
);

    localparam int unsigned SEL_W = sel_width(N_IN);

    logic [N_IN-1:0]  ev_q;
    logic [N_IN-1:0]  ev_d;
    logic [N_IN-1:0]  ev_qq;
    logic [N_IN-1:0]  ev_qq_d;
    logic             pending_q;
    logic             pending_d;

    logic [SEL_W-1:0] sh_sel_q   [N_OUT];
    logic [SEL_W-1:0] sh_sel_d   [N_OUT];
    logic [SEL_W-1:0] act_sel_q  [N_OUT];
    logic [SEL_W-1:0] act_sel_d  [N_OUT];
    route_mode_e      sh_mode_q  [N_OUT];
    route_mode_e      sh_mode_d  [N_OUT];
    route_mode_e      act_mode_q [N_OUT];
    route_mode_e      act_mode_d [N_OUT];

`ifdef PMU_ROUTER_PRESCALE_EN
    logic [PRESC_W-1:0] sh_presc_q  [N_OUT];
    logic [PRESC_W-1:0] sh_presc_d  [N_OUT];
    logic [PRESC_W-1:0] act_presc_q [N_OUT];
    logic [PRESC_W-1:0] act_presc_d [N_OUT];
`else
    logic unused_cfg_presc;
    assign unused_cfg_presc = ^rtr_if.cfg_presc_i;
`endif

    logic [N_OUT-1:0] lane_ev;

    // Write loads shadow; commit copies shadow to active, or cfg_* directly when written in the same cycle.
    always_comb begin
        ev_d       = rtr_if.events_i;
        ev_qq_d    = ev_q;
        pending_d  = pending_q;
        sh_sel_d   = sh_sel_q;
        sh_mode_d  = sh_mode_q;
        act_sel_d  = act_sel_q;
        act_mode_d = act_mode_q;
`ifdef PMU_ROUTER_PRESCALE_EN
        sh_presc_d  = sh_presc_q;
        act_presc_d = act_presc_q;
`endif
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (rtr_if.cfg_we_i) begin
                sh_sel_d[k]  = rtr_if.cfg_sel_i[k*SEL_W +: SEL_W];
                sh_mode_d[k] = route_mode_e'(rtr_if.cfg_mode_i[k*2 +: 2]);
`ifdef PMU_ROUTER_PRESCALE_EN
                sh_presc_d[k] = rtr_if.cfg_presc_i[k*PRESC_W +: PRESC_W];
`endif
            end
            if (rtr_if.commit_i) begin
                act_sel_d[k]  = rtr_if.cfg_we_i ? rtr_if.cfg_sel_i[k*SEL_W +: SEL_W] : sh_sel_q[k];
                act_mode_d[k] = rtr_if.cfg_we_i ? route_mode_e'(rtr_if.cfg_mode_i[k*2 +: 2])
                                                : sh_mode_q[k];
`ifdef PMU_ROUTER_PRESCALE_EN
                act_presc_d[k] = rtr_if.cfg_we_i ? rtr_if.cfg_presc_i[k*PRESC_W +: PRESC_W]
                                                 : sh_presc_q[k];
`endif
            end
        end
        if (rtr_if.commit_i) begin
            pending_d = 1'b0;
        end else if (rtr_if.cfg_we_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ev_q       <= '0;
            ev_qq      <= '0;
            pending_q  <= 1'b0;
            sh_sel_q   <= '{default: '0};
            act_sel_q  <= '{default: '0};
            sh_mode_q  <= '{default: ROUTE_OFF};
            act_mode_q <= '{default: ROUTE_OFF};
`ifdef PMU_ROUTER_PRESCALE_EN
            sh_presc_q  <= '{default: '0};
            act_presc_q <= '{default: '0};
`endif
        end else begin
            ev_q       <= ev_d;
            ev_qq      <= ev_qq_d;
            pending_q  <= pending_d;
            sh_sel_q   <= sh_sel_d;
            act_sel_q  <= act_sel_d;
            sh_mode_q  <= sh_mode_d;
            act_mode_q <= act_mode_d;
`ifdef PMU_ROUTER_PRESCALE_EN
            sh_presc_q  <= sh_presc_d;
            act_presc_q <= act_presc_d;
`endif
        end
    end

    for (genvar k = 0; k < int'(N_OUT); k++) begin : g_lane
        lane_cfg_t lane_cfg;

        always_comb begin
            lane_cfg      = '0;
            lane_cfg.sel  = LANE_SEL_W'(act_sel_q[k]);
            lane_cfg.mode = act_mode_q[k];
`ifdef PMU_ROUTER_PRESCALE_EN
            lane_cfg.presc = LANE_PRESC_W'(act_presc_q[k]);
`endif
        end

        // Commit blanks the output and restarts prescaling on the same edge the new config lands.
        pmu_router_lane #(
            .N_IN    (N_IN),
            .PRESC_W (PRESC_W)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (rtr_if.commit_i),
            .ev_q_i  (ev_q),
            .ev_qq_i (ev_qq),
            .cfg_i   (lane_cfg),
            .event_o (lane_ev[k])
        );
    end

    assign rtr_if.events_o  = lane_ev;
    assign rtr_if.pending_o = pending_q;

endmodule

// File: tb/tb_pmu_event_router.sv
// Scoreboard bench for pmu_event_router: a spec-level model predicts each cycle's outputs into a queue,
// a monitor pops and compares; honours PMU_ROUTER_PRESCALE_EN.
module tb_pmu_event_router;
    import pmu_router_pkg::*;

    localparam int unsigned N_IN    = 32;
    localparam int unsigned N_OUT   = 24;
    localparam int unsigned PRESC_W = 4;
    localparam int unsigned SEL_W   = sel_width(N_IN);

    typedef struct {
        logic [N_OUT-1:0] ev;
        logic             pend;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pmu_event_router_if #(.N_IN(N_IN), .N_OUT(N_OUT), .PRESC_W(PRESC_W)) rtr_if ();

    pmu_event_router #(.N_IN(N_IN), .N_OUT(N_OUT), .PRESC_W(PRESC_W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rtr_if (rtr_if)
    );

    always #5 clk_i = ~clk_i;

    // Staged configuration presented on the cfg_* ports each cycle
    logic [N_OUT*SEL_W-1:0]   c_sel   = '0;
    logic [N_OUT*2-1:0]       c_mode  = '0;
    logic [N_OUT*PRESC_W-1:0] c_presc = '0;

    // Reference model: active/shadow config, hits since last commit, inputs seen one and two edges ago
    int a_sel [N_OUT];
    int a_mode[N_OUT];
    int a_p   [N_OUT];
    int s_sel [N_OUT];
    int s_mode[N_OUT];
    int s_p   [N_OUT];
    int hits  [N_OUT];
    bit m_pend = 1'b0;
    logic [N_IN-1:0] m_now  = '0;
    logic [N_IN-1:0] m_past = '0;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse-count windows: stimulus side writes these, monitor side owns the counts
    bit watch_en   = 1'b0;
    bit watch_seen = 1'b0;
    int watch_lane = 0;
    int watch_exp  = 0;
    int watch_req  = 0;
    int watch_ack  = 0;
    int pulse_cnt[N_OUT];
    bit end_req    = 1'b0;
    int drain_cyc  = 0;

    task automatic model_step(input logic [N_IN-1:0] ev, input bit we, input bit cm, input bit rst);
        exp_t e;
        e.ev   = '0;
        e.pend = 1'b0;
        if (rst) begin
            for (int k = 0; k < int'(N_OUT); k++) begin
                a_sel[k] = 0; a_mode[k] = 0; a_p[k] = 0;
                s_sel[k] = 0; s_mode[k] = 0; s_p[k] = 0;
                hits[k]  = 0;
            end
            m_pend = 1'b0;
            m_now  = '0;
            m_past = '0;
        end else begin
            for (int k = 0; k < int'(N_OUT); k++) begin
                bit lvl, old, hit;
                lvl = (a_sel[k] < int'(N_IN)) && (m_now[a_sel[k]] === 1'b1);
                old = (a_sel[k] < int'(N_IN)) && (m_past[a_sel[k]] === 1'b1);
                case (a_mode[k])
                    1:       hit = lvl;
                    2:       hit = lvl && !old;
                    3:       hit = !lvl && old;
                    default: hit = 1'b0;
                endcase
`ifdef PMU_ROUTER_PRESCALE_EN
                if (hit) begin
                    hits[k]++;
                    e.ev[k] = ((hits[k] % (1 << a_p[k])) == 0);
                end
`else
                e.ev[k] = hit;
`endif
            end
            if (cm) begin
                e.ev = '0;
                for (int k = 0; k < int'(N_OUT); k++) begin
                    hits[k] = 0;
                    if (we) begin
                        s_sel[k]  = int'(c_sel[k*SEL_W +: SEL_W]);
                        s_mode[k] = int'(c_mode[k*2 +: 2]);
                        s_p[k]    = int'(c_presc[k*PRESC_W +: PRESC_W]);
                    end
                    a_sel[k] = s_sel[k]; a_mode[k] = s_mode[k]; a_p[k] = s_p[k];
                end
                m_pend = 1'b0;
            end else if (we) begin
                for (int k = 0; k < int'(N_OUT); k++) begin
                    s_sel[k]  = int'(c_sel[k*SEL_W +: SEL_W]);
                    s_mode[k] = int'(c_mode[k*2 +: 2]);
                    s_p[k]    = int'(c_presc[k*PRESC_W +: PRESC_W]);
                end
                m_pend = 1'b1;
            end
            e.pend = m_pend;
            m_past = m_now;
            m_now  = ev;
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict the response, advance to the next falling edge
    task automatic cycle(input logic [N_IN-1:0] ev, input bit we, input bit cm, input bit rst);
        rtr_if.events_i    = ev;
        rtr_if.cfg_sel_i   = c_sel;
        rtr_if.cfg_mode_i  = c_mode;
        rtr_if.cfg_presc_i = c_presc;
        rtr_if.cfg_we_i    = we;
        rtr_if.commit_i    = cm;
        rst_i              = rst;
        model_step(ev, we, cm, rst);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_lane(input int k, input int sel, input int mode, input int p);
        c_sel[k*SEL_W +: SEL_W]       = SEL_W'(sel);
        c_mode[k*2 +: 2]              = 2'(mode);
        c_presc[k*PRESC_W +: PRESC_W] = PRESC_W'(p);
    endtask

    task automatic clear_cfg();
        c_sel   = '0;
        c_mode  = '0;
        c_presc = '0;
    endtask

    task automatic watch_check(input int lane, input int expv);
        watch_lane = lane;
        watch_exp  = expv;
        watch_req++;
        idle(1);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (watch_en && !watch_seen) begin
            for (int k = 0; k < int'(N_OUT); k++) pulse_cnt[k] = 0;
        end
        watch_seen = watch_en;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (rtr_if.events_o !== mon_e.ev) begin
                n_err++;
                $display("FAIL events_o @%0t: got %h want %h", $time, rtr_if.events_o, mon_e.ev);
            end
            n_cmp++;
            if (rtr_if.pending_o !== mon_e.pend) begin
                n_err++;
                $display("FAIL pending_o @%0t: got %b want %b", $time, rtr_if.pending_o, mon_e.pend);
            end
            if (watch_en) begin
                for (int k = 0; k < int'(N_OUT); k++)
                    if (rtr_if.events_o[k] === 1'b1) pulse_cnt[k]++;
            end
        end
        if (watch_req != watch_ack) begin
            watch_ack = watch_req;
            n_cmp++;
            if (pulse_cnt[watch_lane] != watch_exp) begin
                n_err++;
                $display("FAIL pulse_count lane %0d: got %0d want %0d", watch_lane, pulse_cnt[watch_lane], watch_exp);
            end
        end
        if (end_req) begin
            if (exp_q.size() == 0) begin
                summary();
                $finish;
            end
            drain_cyc++;
            if (drain_cyc > 16) begin
                n_err++;
                $display("FAIL drain: got %0d entries left want 0", exp_q.size());
                summary();
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_IN-1:0] ev;

        // Reset held two cycles with random events, then one cycle after release
        cycle(N_IN'($urandom), 1'b0, 1'b0, 1'b1);
        cycle(N_IN'($urandom), 1'b1, 1'b1, 1'b1);
        cycle(N_IN'($urandom), 1'b0, 1'b0, 1'b0);
        idle(2);

        // Level route lane 5 <- input 17
        clear_cfg();
        set_lane(5, 17, 1, 0);
        cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1, 1'b0);
        idle(2);
        ev = '0;
        ev[17] = 1'b1;
        repeat (3) cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Rising on lane 0, falling on lane 1, both from input 3
        clear_cfg();
        set_lane(0, 3, 2, 0);
        set_lane(1, 3, 3, 0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        idle(2);
        watch_en = 1'b1;
        ev = '0;
        ev[3] = 1'b1;
        repeat (4) cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(4);
        watch_en = 1'b0;
        watch_check(0, 1);
        watch_check(1, 1);

        // Shadow write keeps active routing until commit, then blanks one cycle
        clear_cfg();
        set_lane(2, 1, 1, 0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        set_lane(2, 9, 1, 0);
        cycle('0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ev = '0;
            ev[1] = i[0];
            ev[9] = ~i[0];
            cycle(ev, 1'b0, 1'b0, 1'b0);
        end
        set_lane(2, 4, 2, 0);
        cycle(ev, 1'b1, 1'b0, 1'b0);
        set_lane(2, 9, 1, 0);
        cycle(ev, 1'b1, 1'b0, 1'b0);
        ev = '0;
        ev[9] = 1'b1;
        cycle(ev, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Write-through on lane 0 <- input 31
        clear_cfg();
        set_lane(0, 31, 1, 0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        ev = '0;
        ev[31] = 1'b1;
        repeat (2) cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Prescale p=3 on lane 4, input 0 held high for 20 cycles
        clear_cfg();
        set_lane(4, 0, 1, 3);
        cycle('0, 1'b1, 1'b1, 1'b0);
        idle(2);
        watch_en = 1'b1;
        ev = '0;
        ev[0] = 1'b1;
        repeat (20) cycle(ev, 1'b0, 1'b0, 1'b0);
        idle(4);
        watch_en = 1'b0;
`ifdef PMU_ROUTER_PRESCALE_EN
        watch_check(4, 2);
`else
        watch_check(4, 20);
`endif

        // Sweep every (input, lane) pair in level mode
        for (int s = 0; s < int'(N_IN); s++) begin
            for (int k = 0; k < int'(N_OUT); k++) set_lane(k, (k + s) % int'(N_IN), 1, 0);
            cycle('0, 1'b1, 1'b1, 1'b0);
            cycle('1, 1'b0, 1'b0, 1'b0);
            repeat (3) cycle(N_IN'($urandom), 1'b0, 1'b0, 1'b0);
        end
        idle(2);

        // Randomised traffic, configuration churn and occasional reset
        for (int i = 0; i < 400; i++) begin
            bit we, cm, rs;
            we = ($urandom_range(5) == 0);
            cm = ($urandom_range(6) == 0);
            rs = ($urandom_range(80) == 0);
            if (we) begin
                for (int k = 0; k < int'(N_OUT); k++) begin
                    if ($urandom_range(1) == 1)
                        set_lane(k, int'($urandom_range(N_IN - 1)), int'($urandom_range(3)),
                                 int'($urandom_range(3)));
                end
            end
            cycle(N_IN'($urandom), we, cm, rs);
        end
        idle(4);

        end_req = 1'b1;
    end

endmodule
